// File: rtl/regfile_mp.sv
// Multi-lane register file with per-lane read/write ports, optional write-to-read
// bypass, highest-lane-wins write resolution and per-register busy tracking.
module regfile_mp #(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES*ADDR_W-1:0]   rd_addr_a,
    input  logic [LANES*ADDR_W-1:0]   rd_addr_b,
    output logic [LANES*DATA_W-1:0]   rd_data_a,
    output logic [LANES*DATA_W-1:0]   rd_data_b,
    output logic [LANES-1:0]          rd_busy_a,
    output logic [LANES-1:0]          rd_busy_b,
    input  logic [LANES-1:0]          wr_en,
    input  logic [LANES*ADDR_W-1:0]   wr_addr,
    input  logic [LANES*DATA_W-1:0]   wr_data,
    input  logic [LANES-1:0]          claim_en,
    input  logic [LANES*ADDR_W-1:0]   claim_addr,
    output logic                      wr_conflict
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0][DATA_W-1:0] mem;
    logic [NREG-1:0][DATA_W-1:0] mem_nxt;
    logic [NREG-1:0]             busy;
    logic [NREG-1:0]             busy_nxt;
    logic                        conflict_nxt;
    logic [LANES*DATA_W-1:0]     rd_data_a_nxt;
    logic [LANES*DATA_W-1:0]     rd_data_b_nxt;
    logic [LANES-1:0]            rd_busy_a_nxt;
    logic [LANES-1:0]            rd_busy_b_nxt;

    // Lanes are applied in ascending order so the highest lane's write lands last.
    // Claims follow the clears: a newly issued producer outranks a retiring one.
    always_comb begin
        mem_nxt      = mem;
        busy_nxt     = busy;
        conflict_nxt = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (wr_en[l] && (wr_addr[l*ADDR_W +: ADDR_W] != '0)) begin
                mem_nxt[wr_addr[l*ADDR_W +: ADDR_W]]  = wr_data[l*DATA_W +: DATA_W];
                busy_nxt[wr_addr[l*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        for (int l = 0; l < LANES; l++) begin
            if (claim_en[l] && (claim_addr[l*ADDR_W +: ADDR_W] != '0)) begin
                busy_nxt[claim_addr[l*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (wr_en[i] && wr_en[j] && (wr_addr[i*ADDR_W +: ADDR_W] != '0) &&
                    (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W])) begin
                    conflict_nxt = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_data_a_nxt = '0;
        rd_data_b_nxt = '0;
        rd_busy_a_nxt = '0;
        rd_busy_b_nxt = '0;
        for (int l = 0; l < LANES; l++) begin
            if (rd_addr_a[l*ADDR_W +: ADDR_W] != '0) begin
                rd_data_a_nxt[l*DATA_W +: DATA_W] = BYPASS ? mem_nxt[rd_addr_a[l*ADDR_W +: ADDR_W]]
                                                           : mem[rd_addr_a[l*ADDR_W +: ADDR_W]];
                rd_busy_a_nxt[l] = busy_nxt[rd_addr_a[l*ADDR_W +: ADDR_W]];
            end
            if (rd_addr_b[l*ADDR_W +: ADDR_W] != '0) begin
                rd_data_b_nxt[l*DATA_W +: DATA_W] = BYPASS ? mem_nxt[rd_addr_b[l*ADDR_W +: ADDR_W]]
                                                           : mem[rd_addr_b[l*ADDR_W +: ADDR_W]];
                rd_busy_b_nxt[l] = busy_nxt[rd_addr_b[l*ADDR_W +: ADDR_W]];
            end
        end
    end

    // State and registered read outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            mem         <= '0;
            busy        <= '0;
            rd_data_a   <= '0;
            rd_data_b   <= '0;
            rd_busy_a   <= '0;
            rd_busy_b   <= '0;
            wr_conflict <= 1'b0;
        end else begin
            mem         <= mem_nxt;
            busy        <= busy_nxt;
            rd_data_a   <= rd_data_a_nxt;
            rd_data_b   <= rd_data_b_nxt;
            rd_busy_a   <= rd_busy_a_nxt;
            rd_busy_b   <= rd_busy_b_nxt;
            wr_conflict <= conflict_nxt;
        end
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with write-back scoreboard, successor to the fixed dual-lane `regs` block of the issue pipeline. It serves LANES issue lanes, with two read ports and one write port per lane, and registered read data. It adds three things the dual-lane block lacks: optional write-to-read bypass, deterministic same-cycle write-conflict resolution, and per-register busy tracking, so that `dec` can hold an instruction whose source operand is still in flight.

## Interface
- LANES, 2, number of issue lanes (1..4)
- DATA_W, 32, register width
- ADDR_W, 5, register index width; 2**ADDR_W registers
- BYPASS, 1, 1 = a same-cycle write is visible on read data; 0 = the old value is returned
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- rd_addr_a  in  LANES*ADDR_W  first source index per lane; lane i occupies slice [i*ADDR_W +: ADDR_W]
- rd_addr_b  in  LANES*ADDR_W  second source index per lane
- rd_data_a  out  LANES*DATA_W  registered first operand per lane
- rd_data_b  out  LANES*DATA_W  registered second operand per lane
- rd_busy_a  out  LANES  registered busy flag for the register addressed on port a
- rd_busy_b  out  LANES  registered busy flag for the register addressed on port b
- wr_en  in  LANES  write-back enable per lane
- wr_addr  in  LANES*ADDR_W  write-back index per lane
- wr_data  in  LANES*DATA_W  write-back data per lane
- claim_en  in  LANES  dispatch marks the destination register busy
- claim_addr  in  LANES*ADDR_W  destination index being claimed
- wr_conflict  out  1  registered pulse: two or more lanes wrote the same nonzero index in the previous cycle

## Operation
- Register 0 always reads 0 and is never busy. Writes and claims to index 0 are ignored.
- Write: at each edge, for every lane with wr_en set, mem[wr_addr] <= wr_data. It also clears busy[wr_addr].
- Write conflict: if several lanes write the same index, the highest lane index wins. wr_conflict is 1 for the following cycle. Writes to different indices all commit.
- Claim: claim_en sets busy[claim_addr]. A claim on a register that is already busy leaves it busy.
- Claim and write-back to the same index in the same cycle: the claim wins and the bit ends the cycle set, because a new producer has been issued.
- Read: rd_data_x lane i <= mem[rd_addr_x lane i] at each edge.
  - BYPASS=1: if any lane writes that index in the same cycle, the winning write data is returned instead.
  - Index 0 always returns 0.
- Busy read: rd_busy_x <= the next-state busy bit of the addressed register, i.e. after this cycle's claims and clears are applied.
- The block has no stall output. `dec` combines rd_busy_a and rd_busy_b to form its stall.

## Timing
- Read latency is 1 cycle: the address is presented in cycle n and the data and busy flag are valid after edge n+1.
- Write latency is 1 cycle. With BYPASS=0, a read of the same index in the same cycle returns the pre-write value; the new value appears from the next read onward.
- Busy clears on the edge of the write-back and sets on the edge of the claim.
- Reset (rst=1 at an edge):
  - all registers cleared to 0
  - all busy bits cleared
  - rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, wr_conflict all 0
  - wr_en and claim_en in the same cycle are ignored
- Reset applied mid-operation discards every pending claim. In-flight write-backs arriving after reset still commit normally.
- Port activity is independent across lanes. All lanes may read, write and claim in the same cycle.

## Test plan
- Reset then read: rst for 2 cycles, then all lanes read indices 1..4 -> rd_data=0, rd_busy=0, wr_conflict=0.
- Write and read-back: lane0 writes r5=0xDEADBEEF. Next cycle lane1 port b reads r5 -> 0xDEADBEEF after one edge. A write to r0 of 0x1234, then a read of r0 -> 0.
- Bypass: lane1 writes r7=0x55, and in the same cycle lane0 port a reads r7.
  - BYPASS=1: 0x55.
  - BYPASS=0: old value 0, then 0x55 on the following read.
- Write conflict: lane0 writes r3=0xA and lane1 writes r3=0xB in the same cycle -> wr_conflict=1 for exactly one cycle, and r3 reads 0xB.
- Scoreboard:
  - claim r9 -> a read of r9 next cycle shows busy=1.
  - write-back r9=0x77 with no claim -> busy=0 and data 0x77.
  - claim and write-back to r9 in the same cycle -> busy stays 1.
- Reset mid-flight: claim r10 and r11, assert rst for one cycle -> reads of r10 and r11 show busy=0 and data=0.
